// File: rtl/pkt_output_arbiter_if.sv
// Requester-side and frame-bus signals of the packet output arbiter.
// The master modport is the requester/bench side, slave is the arbiter.
interface pkt_output_arbiter_if;
    logic [2:0]   iv_req;
    logic [2:0]   ov_ack;
    logic [133:0] iv_data_0;
    logic [133:0] iv_data_1;
    logic [133:0] iv_data_2;
    logic [2:0]   iv_req_mask;
    logic [133:0] ov_data;
    logic         o_data_wr;
    logic [1:0]   ov_src_id;
    logic         o_timeout;
    logic [15:0]  ov_timeout_cnt;

    modport master (
        output iv_req, iv_data_0, iv_data_1, iv_data_2, iv_req_mask,
        input  ov_ack, ov_data, o_data_wr, ov_src_id, o_timeout, ov_timeout_cnt
    );

    modport slave (
        input  iv_req, iv_data_0, iv_data_1, iv_data_2, iv_req_mask,
        output ov_ack, ov_data, o_data_wr, ov_src_id, o_timeout, ov_timeout_cnt
    );
endinterface

// File: rtl/pkt_output_arbiter.sv
// Round-robin, packet-atomic arbiter of three req/ack frame sources onto one
// 134-bit frame bus, with a per-packet length guard that forces a tail.
module pkt_output_arbiter #(
    parameter int unsigned MAX_PKT_WORDS = 128
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pkt_output_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACK   = 2'd1;
    localparam logic [1:0] S_TRANS = 2'd2;

    localparam logic [1:0] TAG_TAIL = 2'b10;

    logic [1:0]   state_q,   state_d;
    logic [1:0]   ptr_q,     ptr_d;
    logic [1:0]   grant_q,   grant_d;
    logic [2:0]   ack_q,     ack_d;
    logic [7:0]   cnt_q,     cnt_d;
    logic [133:0] data_q,    data_d;
    logic         wr_q,      wr_d;
    logic [1:0]   src_q,     src_d;
    logic         to_q,      to_d;
    logic [15:0]  to_cnt_q,  to_cnt_d;

    logic [2:0]   eligible;
    logic [1:0]   pick;
    logic [133:0] sample;
    logic         is_tail;
    logic         last_allowed;

    // First eligible index after ptr, wrapping modulo 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(ptr) + k) % 3);
            if (elig[idx]) rr_pick = idx;
        end
    endfunction

    assign eligible     = bus.iv_req & ~bus.iv_req_mask;
    assign pick         = rr_pick(eligible, ptr_q);
    assign is_tail      = (sample[133:132] == TAG_TAIL);
    assign last_allowed = (cnt_q == 8'(MAX_PKT_WORDS - 1));

    always_comb begin
        case (grant_q)
            2'd1:    sample = bus.iv_data_1;
            2'd2:    sample = bus.iv_data_2;
            default: sample = bus.iv_data_0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path through
        // the case below leaves one unassigned and infers a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        to_cnt_d = to_cnt_q;
        ack_d    = 3'b000;
        data_d   = '0;
        wr_d     = 1'b0;
        to_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    grant_d = pick;
                    ptr_d   = pick;
                    ack_d   = 3'b001 << pick;
                    cnt_d   = 8'd0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_TRANS;
            end
            S_TRANS: begin
                data_d = sample;
                wr_d   = 1'b1;
                src_d  = grant_q;
                cnt_d  = cnt_q + 8'd1;
                if (is_tail) begin
                    state_d = S_IDLE;
                end else if (last_allowed) begin
                    // Runaway frame: close it ourselves so the bus is released.
                    data_d[133:132] = TAG_TAIL;
                    to_d            = 1'b1;
                    if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the reset branch covers every register, so an aborted packet leaves
    // no stale word or grant behind; state updates use <= so all registers move
    // together on the edge regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 2'd2;
            grant_q  <= 2'd0;
            ack_q    <= 3'b000;
            cnt_q    <= 8'd0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            src_q    <= 2'd0;
            to_q     <= 1'b0;
            to_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            src_q    <= src_d;
            to_q     <= to_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign bus.ov_ack         = ack_q;
    assign bus.ov_data        = data_q;
    assign bus.o_data_wr      = wr_q;
    assign bus.ov_src_id      = src_q;
    assign bus.o_timeout      = to_q;
    assign bus.ov_timeout_cnt = to_cnt_q;

endmodule
